// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control unit for the shared ALU/memory datapath.
// Moore FSM with registered strobes. illegal_op is decoded from the current
// state plus opcode/funct.
// Optional feature macro: CTRL_OVF_TRAP_EN. When defined, a signed overflow
// on add/sub/addi suppresses the write-back and diverts to TRAP. The default
// build (macro undefined) never reaches TRAP.
module mc_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        overflow,
  output logic        alu_src_a,
  output logic [3:0]  alu_src_b,
  output logic [2:0]  alu_ctrl,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        reg_dst,
  output logic        iord,
  output logic        epc_write,
  output logic [1:0]  pc_source,
  output logic        illegal_op,
  output logic [3:0]  state_o,
  output logic [31:0] pc_load_val
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_REXEC  = 4'd7,
    S_RWB    = 4'd8,  S_BRANCH = 4'd9, S_JUMP   = 4'd10, S_IEXEC  = 4'd11,
    S_IWB    = 4'd12, S_TRAP  = 4'd13
  } state_e;

  typedef struct packed {
    logic       alu_src_a;
    logic [3:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       iord;
    logic       epc_write;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   op_known, fn_known, ovf_trap;

  // Strobe pattern for a given state; funct only matters in REXEC, where IR is already stable.
  function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_RESET:  begin c.pc_write = 1'b1; c.pc_source = 2'd3; end
      S_FETCH:  begin
        c.mem_read = 1'b1; c.ir_write = 1'b1; c.alu_src_b = 4'd1;
        c.alu_ctrl = ALU_ADD; c.pc_write = 1'b1;
      end
      S_DECODE: begin c.alu_src_b = 4'd3; c.alu_ctrl = ALU_ADD; end
      S_MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 4'd2; c.alu_ctrl = ALU_ADD; end
      S_MEMRD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_MEMWR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      S_REXEC:  begin
        c.alu_src_a = 1'b1;
        case (fn)
          FN_SUB:  c.alu_ctrl = ALU_SUB;
          FN_AND:  c.alu_ctrl = ALU_AND;
          FN_OR:   c.alu_ctrl = ALU_OR;
          FN_SLT:  c.alu_ctrl = ALU_SLT;
          default: c.alu_ctrl = ALU_ADD;
        endcase
      end
      S_RWB:    begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_BRANCH: begin
        c.alu_src_a = 1'b1; c.alu_ctrl = ALU_SUB;
        c.pc_write_cond = 1'b1; c.pc_source = 2'd1;
      end
      S_JUMP:   begin c.pc_write = 1'b1; c.pc_source = 2'd2; end
      S_IEXEC:  begin c.alu_src_a = 1'b1; c.alu_src_b = 4'd2; c.alu_ctrl = ALU_ADD; end
      S_IWB:    c.reg_write = 1'b1;
      S_TRAP:   begin c.epc_write = 1'b1; c.pc_write = 1'b1; c.pc_source = 2'd3; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                    (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);
  assign fn_known = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR) || (funct == FN_SLT);

`ifdef CTRL_OVF_TRAP_EN
  assign ovf_trap = overflow &&
                    (((state_q == S_RWB) && ((funct == FN_ADD) || (funct == FN_SUB))) ||
                     (state_q == S_IWB));
  assign epc_write = ctrl_q.epc_write;
  logic unused_in;
  assign unused_in = zero;
`else
  assign ovf_trap  = 1'b0;
  assign epc_write = 1'b0;
  logic unused_in;
  assign unused_in = ^{zero, overflow, ctrl_q.epc_write};
`endif

  // Next-state decode from the current state and the IR fields.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:  state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_REXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_IEXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      S_RWB, S_IWB: state_d = ovf_trap ? S_TRAP : S_FETCH;
      default:  state_d = S_FETCH;
    endcase
    ctrl_d = ctrl_for(state_d, funct);
  end

  // State register and registered strobes for the state being entered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_RESET;
      ctrl_q  <= ctrl_for(S_RESET, funct);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_ctrl      = ctrl_q.alu_ctrl;
  assign pc_write      = ctrl_q.pc_write;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign ir_write      = ctrl_q.ir_write;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign reg_write     = ctrl_q.reg_write & ~ovf_trap;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign iord          = ctrl_q.iord;
  assign pc_source     = ctrl_q.pc_source;
  assign state_o       = state_q;
  assign pc_load_val   = (state_q == S_RESET) ? RESET_PC : 32'h0;
  assign illegal_op    = ((state_q == S_DECODE) && !op_known) ||
                         ((state_q == S_REXEC) && !fn_known);

endmodule
